mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage; consumes the EX/MEM register outputs and feeds the MEM/WB register.
- Executes LB/LBU/LH/LHU/LW/SB/SH/SW over a single-outstanding req/ack data bus.
- Raises stallreq to the pipeline controller, which freezes EX/MEM (stall[3]) while the access is in flight.
- Non-memory ops pass straight through with zero latency.

Parameters:
- TIMEOUT_CYCLES, 16: ack wait limit in BUSY; used only when MEM_BUS_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  write enable from EX/MEM
- mem_wdata  in  32  ALU result from EX/MEM
- mem_aluop  in  8  operation code
- mem_mem_addr  in  32  effective address
- mem_reg2  in  32  store data source
- wb_wd  out  5  to MEM/WB
- wb_wreg  out  1  to MEM/WB
- wb_wdata  out  32  to MEM/WB
- stallreq  out  1  stage busy; hold upstream
- bus_req  out  1  transaction request (registered)
- bus_we  out  1  1 = write (registered)
- bus_addr  out  32  word address, {addr[31:2],2'b00} (registered)
- bus_sel  out  4  byte lanes, bit3 = bits[31:24] (registered)
- bus_wdata  out  32  store data (registered)
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe
- bus_err  out  1  timeout pulse (exists only with the optional feature)

Behaviour:
- Opcodes:
  - LB=8'hE0, LBU=8'hE4, LH=8'hE1, LHU=8'hE5, LW=8'hE3.
  - SB=8'hE8, SH=8'hE9, SW=8'hEB.
  - Any other value is a non-memory op.
- Big-endian lanes:
  - addr[1:0] 00/01/10/11 selects sel 1000/0100/0010/0001 and bytes [31:24]/[23:16]/[15:8]/[7:0].
  - Halfword: addr[1]=0 gives sel 1100 and [31:16]; addr[1]=1 gives sel 0011 and [15:0].
  - Word: sel 1111.
- Store data:
  - SB drives {4{reg2[7:0]}}.
  - SH drives {2{reg2[15:0]}}.
  - SW drives reg2.
- Load extension:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend it.
  - LW takes the full word.
- Misaligned access:
  - Definition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No bus transaction is issued; stallreq=0.
  - wb_wreg=0, wb_wd=mem_wd, wb_wdata=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory op: wb_* = mem_* combinationally; stallreq=0.
  - Aligned memory op: stallreq=1 (combinational) and wb_* = NOP (0,0,0). Next edge loads the bus_* registers, sets bus_req=1 and enters BUSY.
- BUSY:
  - stallreq=1; wb_* = NOP; bus_* are held stable.
  - On bus_ack: capture the extended load data into a result register, clear bus_req on that edge, enter DONE.
- DONE (exactly 1 cycle):
  - stallreq=0; bus_req=0.
  - Load: wb_wd=mem_wd, wb_wreg=mem_wreg, wb_wdata=result.
  - Store: wb_wreg=0, wb_wdata=0.
  - Next edge returns to IDLE. The upstream pipeline advances on that same edge.
- Latency:
  - Ack in the first BUSY cycle gives 2 stall cycles; each extra wait cycle adds 1.
  - Throughput is one access per 3 cycles minimum.
- bus_ack outside BUSY is ignored (no state change, no capture).
- Reset:
  - bus_req, bus_we, bus_addr, bus_sel, bus_wdata, result and bus_err all go to 0; state goes to IDLE.
  - While rst=1: wb_* = NOP and stallreq=0.
  - A reset mid-BUSY abandons the transaction; bus_req drops on the reset edge.

Optional Feature:
- MEM_BUS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack: clear bus_req, pulse bus_err for 1 cycle, enter DONE with wb_wreg=0.
  - An ack in the same cycle as the timeout wins (normal completion, no bus_err).
- MEM_BUS_TIMEOUT_EN undefined:
  - No counter and no bus_err port; BUSY waits indefinitely.

Test Plan:
- ALU op aluop=8'h21, wd=3, wreg=1, wdata=32'h1234 -> same cycle wb=(3,1,32'h1234), stallreq=0, bus_req never set.
- LB at addr 32'h101, ack 1 cycle after req, rdata=32'h00F10000 -> bus_sel=0100, bus_addr=32'h100; stallreq high 2 cycles; DONE gives wb_wdata=32'hFFFFFFF1, wreg=1.
- SH at addr 32'h202, reg2=32'hAAAA5678, ack after 3 wait cycles -> bus_we=1, sel=0011, wdata=32'h56785678; stallreq high 5 cycles; DONE wb_wreg=0.
- LW at addr 32'h3 -> no bus_req, stallreq=0, wb_wreg=0; LHU at 32'h2 with rdata 32'h0000BEEF -> wb_wdata=32'h0000BEEF.
- Assert rst during BUSY; then a stray bus_ack in IDLE -> bus_req=0 after the edge, state IDLE, no capture, wb=NOP.
- With MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, then bus_err 1-cycle pulse, DONE with wb_wreg=0, then IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: byte/half/word loads and stores over a single-outstanding req/ack bus; other ops pass through.
// Latency: non-memory ops 0 cycles; an aligned access stalls for 2 cycles plus the ack wait cycles, then retires in DONE.
// Backpressure: stallreq holds EX/MEM while an access is in flight. `define MEM_BUS_TIMEOUT_EN adds an ack timeout and bus_err.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
`ifdef MEM_BUS_TIMEOUT_EN
    output logic        bus_err,
`endif
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("mem_stage: TIMEOUT_CYCLES must be within 2..255");
        end
    endgenerate

    state_t      state;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        ld_signed;
    logic [1:0]  size;
    logic        misaligned;
    logic        go;
    logic [3:0]  lane_sel;
    logic [31:0] store_data;

    logic        ld_q;
    logic        ld_sgn_q;
    logic [1:0]  ld_size_q;
    logic [1:0]  ld_off_q;
    logic [31:0] result;
    logic        timed_out;

`ifdef MEM_BUS_TIMEOUT_EN
    logic [7:0]  cnt;
    logic        timed_out_q;
    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

    // Big-endian lanes: offset 0 is bits [31:24].
    function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] sz,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = off[1] ? d[15:0] : d[31:16];
        case (sz)
            SZ_B:    r = {{24{sgn & b[7]}}, b};
            SZ_H:    r = {{16{sgn & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        size      = SZ_W;
        case (mem_aluop)
            OP_LB:   begin is_load = 1'b1;  size = SZ_B; ld_signed = 1'b1; end
            OP_LBU:  begin is_load = 1'b1;  size = SZ_B; end
            OP_LH:   begin is_load = 1'b1;  size = SZ_H; ld_signed = 1'b1; end
            OP_LHU:  begin is_load = 1'b1;  size = SZ_H; end
            OP_LW:   begin is_load = 1'b1;  size = SZ_W; end
            OP_SB:   begin is_store = 1'b1; size = SZ_B; end
            OP_SH:   begin is_store = 1'b1; size = SZ_H; end
            OP_SW:   begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = is_mem &&
                        ((size == SZ_H && mem_mem_addr[0]) ||
                         (size == SZ_W && mem_mem_addr[1:0] != 2'b00));
    assign go         = (state == IDLE) && is_mem && !misaligned;

    always_comb begin
        lane_sel   = 4'b1111;
        store_data = mem_reg2;
        case (size)
            SZ_B: begin
                lane_sel   = 4'b1000 >> mem_mem_addr[1:0];
                store_data = {4{mem_reg2[7:0]}};
            end
            SZ_H: begin
                lane_sel   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
                store_data = {2{mem_reg2[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
            result    <= 32'd0;
            ld_q      <= 1'b0;
            ld_sgn_q  <= 1'b0;
            ld_size_q <= SZ_B;
            ld_off_q  <= 2'd0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt         <= 8'd0;
            timed_out_q <= 1'b0;
            bus_err     <= 1'b0;
`endif
        end else begin
`ifdef MEM_BUS_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (go) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {mem_mem_addr[31:2], 2'b00};
                        bus_sel   <= lane_sel;
                        bus_wdata <= is_store ? store_data : 32'd0;
                        ld_q      <= is_load;
                        ld_sgn_q  <= ld_signed;
                        ld_size_q <= size;
                        ld_off_q  <= mem_mem_addr[1:0];
                        state     <= BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
                        cnt         <= 8'd0;
                        timed_out_q <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        result  <= extend_load(bus_rdata, ld_size_q, ld_off_q, ld_sgn_q);
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    // An ack arriving on the timeout cycle takes priority above.
                    else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        bus_req     <= 1'b0;
                        bus_err     <= 1'b1;
                        timed_out_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_wd    = 5'd0;
        wb_wreg  = 1'b0;
        wb_wdata = 32'd0;
        stallreq = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        wb_wd    = mem_wd;
                        wb_wreg  = mem_wreg;
                        wb_wdata = mem_wdata;
                    end else if (misaligned) begin
                        wb_wd = mem_wd;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                BUSY: stallreq = 1'b1;
                DONE: begin
                    // EX/MEM is still frozen here, so mem_* describe the retiring access.
                    wb_wd = mem_wd;
                    if (ld_q && !timed_out) begin
                        wb_wreg  = mem_wreg;
                        wb_wdata = result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: driver pushes expected retire results, a monitor and a bus responder check them.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

`ifndef MEM_BUS_TIMEOUT_EN
    assign bus_err = 1'b0;
`endif

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        err;
        int          stalls;
    } exp_wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        ack;
    } exp_bus_t;

    exp_wb_t  wb_q[$];
    exp_bus_t bus_q[$];

    int   checks = 0;
    int   failures = 0;
    logic active = 1'b0;
    logic rst_q = 1'b0;
    int   stall_run = 0;
    logic [7:0] mem_ops [8];

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .stallreq     (stallreq),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_sel      (bus_sel),
        .bus_wdata    (bus_wdata),
`ifdef MEM_BUS_TIMEOUT_EN
        .bus_err      (bus_err),
`endif
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rst_q <= rst;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    function automatic bit is_mem_op(input logic [7:0] op);
        return op inside {8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};
    endfunction

    // Reference model: access size in bytes, big-endian byte numbering, plain shifts and masks.
    task automatic issue(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int waits, input bit wait_commit);
        int nb, off, n;
        bit ld, st, sgn, mis, tmo;
        logic [31:0] msk, val, rep;
        exp_wb_t  ew;
        exp_bus_t eb;
        nb = 0; ld = 0; st = 0; sgn = 0;
        case (op)
            8'hE0: begin ld = 1; nb = 1; sgn = 1; end
            8'hE4: begin ld = 1; nb = 1; end
            8'hE1: begin ld = 1; nb = 2; sgn = 1; end
            8'hE5: begin ld = 1; nb = 2; end
            8'hE3: begin ld = 1; nb = 4; end
            8'hE8: begin st = 1; nb = 1; end
            8'hE9: begin st = 1; nb = 2; end
            8'hEB: begin st = 1; nb = 4; end
            default: ;
        endcase
        off = int'(addr[1:0]);
        mis = (nb != 0) && (off % nb != 0);
        tmo = 0;
`ifdef MEM_BUS_TIMEOUT_EN
        tmo = (nb != 0) && !mis && (waits >= TO);
`endif
        msk = (nb == 4 || nb == 0) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
        ew.wd = wd; ew.wreg = 1'b0; ew.wdata = 32'd0; ew.err = tmo; ew.stalls = 0;
        if (nb == 0) begin
            ew.wreg  = wreg;
            ew.wdata = wdata;
        end else if (!mis) begin
            ew.stalls = tmo ? TO + 1 : waits + 2;
            if (ld && !tmo) begin
                val = (rdata >> (8 * (4 - off - nb))) & msk;
                if (sgn && val[8 * nb - 1]) val = val | ~msk;
                ew.wreg  = wreg;
                ew.wdata = val;
            end
            rep = (nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'h1;
            eb.we    = st;
            eb.addr  = addr & ~32'h3;
            eb.sel   = 4'(((1 << nb) - 1) << (4 - off - nb));
            eb.wdata = (reg2 & msk) * rep;
            eb.rdata = rdata;
            eb.waits = waits;
            eb.ack   = !tmo;
            bus_q.push_back(eb);
        end
        wb_q.push_back(ew);
        mem_aluop = op; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        mem_mem_addr = addr; mem_reg2 = reg2;
        if (wait_commit) begin
            n = 0;
            @(negedge clk);
            while (stallreq && n < 100) begin
                n++;
                @(negedge clk);
            end
            if (n >= 100) begin
                checks++;
                failures++;
                $display("FAIL commit_wait stallreq held %0d cycles, required release", n);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Bus responder: checks request fields, then acks after the planned wait count.
    initial begin : responder
        exp_bus_t eb;
        int n;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus_req && !rst) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_unexpected_req addr=%h required no request", bus_addr);
                    n = 0;
                    while (bus_req && n < 300) begin @(negedge clk); n++; end
                end else begin
                    eb = bus_q.pop_front();
                    chk("bus_ctrl", 64'({bus_we, bus_sel}), 64'({eb.we, eb.sel}));
                    chk("bus_addr", 64'(bus_addr), 64'(eb.addr));
                    if (eb.we) chk("bus_wdata", 64'(bus_wdata), 64'(eb.wdata));
                    if (eb.ack) begin
                        repeat (eb.waits) @(negedge clk);
                        bus_ack = 1'b1;
                        bus_rdata = eb.rdata;
                        @(negedge clk);
                        bus_ack = 1'b0;
                        bus_rdata = $urandom;
                    end else begin
                        n = 0;
                        while (bus_req && n < 300) begin @(negedge clk); n++; end
                    end
                end
            end
        end
    end

    // Monitor: every non-stalled cycle retires one instruction.
    initial begin : monitor
        exp_wb_t ew;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_outputs", 64'({stallreq, wb_wd, wb_wreg, wb_wdata}), 64'd0);
                if (rst_q) begin
                    chk("rst_bus_ctrl", 64'({bus_req, bus_we, bus_sel, bus_err}), 64'd0);
                    chk("rst_bus_data", {bus_addr, bus_wdata}, 64'd0);
                end
                stall_run = 0;
            end else if (active) begin
                if (stallreq) begin
                    stall_run++;
                    chk("stall_nop", 64'({wb_wd, wb_wreg, wb_wdata, bus_err}), 64'd0);
                end else if (wb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL retire_unexpected wb_wd=%0d required queued entry", wb_wd);
                end else begin
                    ew = wb_q.pop_front();
                    chk("wb", 64'({wb_wd, wb_wreg, wb_wdata}), 64'({ew.wd, ew.wreg, ew.wdata}));
                    chk("stall_cycles", 64'(stall_run), 64'(ew.stalls));
                    chk("retire_flags", 64'({bus_req, bus_err}), 64'({1'b0, ew.err}));
                    stall_run = 0;
                end
            end else begin
                stall_run = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic random_ops(input int count);
        int r, w;
        logic [7:0] op;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 11);
            if (r < 8) begin
                op = mem_ops[r];
            end else begin
                op = 8'($urandom);
                while (is_mem_op(op)) op = 8'($urandom);
            end
`ifdef MEM_BUS_TIMEOUT_EN
            w = $urandom_range(0, 6);
`else
            w = $urandom_range(0, 5);
`endif
            issue(op, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom, $urandom, $urandom, w, 1);
        end
    endtask

    initial begin : driver
        int n;
        mem_ops = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};
        rst = 1'b1;
        mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
        mem_aluop = 8'd0; mem_mem_addr = 32'd0; mem_reg2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        active = 1'b1;

        issue(8'h21, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 1);
        issue(8'hE0, 5'd5, 1'b1, 32'h0, 32'h101, 32'h0, 32'h00F1_0000, 0, 1);
        issue(8'hE9, 5'd6, 1'b1, 32'h0, 32'h202, 32'hAAAA_5678, 32'h0, 3, 1);
        issue(8'hE3, 5'd7, 1'b1, 32'h0, 32'h3, 32'h0, 32'h0, 0, 1);
        issue(8'hE5, 5'd8, 1'b1, 32'h0, 32'h2, 32'h0, 32'h0000_BEEF, 1, 1);
`ifdef MEM_BUS_TIMEOUT_EN
        issue(8'hE3, 5'd9, 1'b1, 32'h0, 32'h40, 32'h0, 32'h1234_5678, 20, 1);
        issue(8'hE4, 5'd10, 1'b1, 32'h0, 32'h43, 32'h0, 32'h0000_0080, TO - 1, 1);
`endif
        random_ops(400);

        // Reset during BUSY; the planned ack then lands while the stage is idle.
        issue(8'hE3, 5'd1, 1'b1, 32'h0, 32'h80, 32'h0, 32'hCAFE_F00D, 3, 0);
        void'(wb_q.pop_back());
        active = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", 64'({bus_req, stallreq}), 64'd0);
        rst = 1'b0;
        mem_aluop = 8'h5A; mem_wd = 5'd12; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_ack && n < 20);
        chk("stray_ack_seen", 64'(bus_ack), 64'd1);
        @(posedge clk); #1;
        chk("stray_ack_idle", 64'({bus_req, stallreq, wb_wd, wb_wreg, wb_wdata}),
            64'({1'b0, 1'b0, 5'd12, 1'b1, 32'hDEAD_0001}));
        @(posedge clk); #1;
        chk("stray_ack_still_idle", 64'({bus_req, stallreq}), 64'd0);
        active = 1'b1;

        issue(8'hE5, 5'd4, 1'b1, 32'h0, 32'h2, 32'h0, 32'h0000_BEEF, 1, 1);
        random_ops(30);
        active = 1'b0;
        repeat (3) @(posedge clk);
        chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
